// File: rtl/axis_demux_pkg.sv
// ----------------------------------------------------------------------------
// axis_demux_pkg
// Shared types and constants for the 1-to-2 packet-aware AXI-Stream demux.
//   route_state_t : packet-lock state of the demux FSM
//   ROUTE_M1/M2   : encoding of the route select (sel / effective route)
//   lock_state()  : maps a route to the state that locks a packet to it
// ----------------------------------------------------------------------------
package axis_demux_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PKT1 = 2'd1,
        PKT2 = 2'd2
    } route_state_t;

    localparam logic ROUTE_M1 = 1'b0;
    localparam logic ROUTE_M2 = 1'b1;

    function automatic route_state_t lock_state(input logic route);
        return (route == ROUTE_M2) ? PKT2 : PKT1;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// ----------------------------------------------------------------------------
// axis_out_reg
// One-entry registered AXI-Stream output stage. A load takes priority over a
// drain, so a new beat can replace the one leaving in the same cycle.
//   clk, rst          : clock, asynchronous active-low reset
//   load              : capture d_tdata/d_tlast and raise m_tvalid
//   d_tdata, d_tlast  : beat to capture
//   m_tdata/m_tvalid/m_tlast/m_tready : registered master stream
//   can_load          : stage is empty or draining this cycle
// ----------------------------------------------------------------------------
module axis_out_reg
    import axis_demux_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] d_tdata,
    input  logic          d_tlast,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    output logic          can_load
);

    assign can_load = !m_tvalid || m_tready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            m_tvalid <= 1'b0;
        end else if (load) begin
            m_tdata  <= d_tdata;
            m_tlast  <= d_tlast;
            m_tvalid <= 1'b1;
        end else if (m_tvalid && m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_demux_1_2.sv
// ----------------------------------------------------------------------------
// axis_demux_1_2
// Packet-aware 1-to-2 AXI-Stream demultiplexer. The route is taken from sel
// on the first beat of a packet and held until its tlast beat is accepted.
// Each master output is registered (one cycle latency, full throughput).
//
//   state | meaning
//   IDLE  | no packet open, route follows sel combinationally
//   PKT1  | packet open and locked to master 1
//   PKT2  | packet open and locked to master 2
//
// Ports:
//   clk, rst                          : clock, asynchronous active-low reset
//   sel                               : route select (0 = m1, 1 = m2)
//   s_tdata/s_tvalid/s_tlast/s_tready : slave stream
//   m1_* / m2_*                       : registered master streams
//   busy                              : a packet is open
// ----------------------------------------------------------------------------
module axis_demux_1_2
    import axis_demux_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    input  logic          s_tlast,
    output logic          s_tready,
    output logic [DW-1:0] m1_tdata,
    output logic          m1_tvalid,
    output logic          m1_tlast,
    input  logic          m1_tready,
    output logic [DW-1:0] m2_tdata,
    output logic          m2_tvalid,
    output logic          m2_tlast,
    input  logic          m2_tready,
    output logic          busy
);

    route_state_t state;
    route_state_t state_nxt;
    logic         route;
    logic         accept;
    logic         can_load_m1;
    logic         can_load_m2;
    logic         load_m1;
    logic         load_m2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        route     = sel;
        state_nxt = state;
        case (state)
            IDLE: begin
                route = sel;
                // A single-beat packet never opens a lock.
                if (accept && !s_tlast) begin
                    state_nxt = lock_state(sel);
                end
            end
            PKT1: begin
                route = ROUTE_M1;
                if (accept && s_tlast) begin
                    state_nxt = IDLE;
                end
            end
            PKT2: begin
                route = ROUTE_M2;
                if (accept && s_tlast) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                route     = sel;
                state_nxt = IDLE;
            end
        endcase
    end

    // Only the routed port's stage gates the slave; the other port's
    // tready is never on this path.
    assign s_tready = rst && ((route == ROUTE_M2) ? can_load_m2 : can_load_m1);
    assign accept   = s_tvalid && s_tready;
    assign load_m1  = accept && (route == ROUTE_M1);
    assign load_m2  = accept && (route == ROUTE_M2);
    assign busy     = (state != IDLE);

    axis_out_reg #(.DW(DW)) u_out_m1 (
        .clk      (clk),
        .rst      (rst),
        .load     (load_m1),
        .d_tdata  (s_tdata),
        .d_tlast  (s_tlast),
        .m_tdata  (m1_tdata),
        .m_tvalid (m1_tvalid),
        .m_tlast  (m1_tlast),
        .m_tready (m1_tready),
        .can_load (can_load_m1)
    );

    axis_out_reg #(.DW(DW)) u_out_m2 (
        .clk      (clk),
        .rst      (rst),
        .load     (load_m2),
        .d_tdata  (s_tdata),
        .d_tlast  (s_tlast),
        .m_tdata  (m2_tdata),
        .m_tvalid (m2_tvalid),
        .m_tlast  (m2_tlast),
        .m_tready (m2_tready),
        .can_load (can_load_m2)
    );

endmodule

// File: tb/tb_axis_demux_1_2.sv
// ----------------------------------------------------------------------------
// tb_axis_demux_1_2
// Self-checking bench for axis_demux_1_2: directed packets from the test plan
// with literal expectations, then randomized traffic with random backpressure.
// A per-port queue model predicts every output on every cycle.
// ----------------------------------------------------------------------------
module tb_axis_demux_1_2;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       s_tready;
    logic [7:0] m1_tdata;
    logic       m1_tvalid;
    logic       m1_tlast;
    logic       m1_tready;
    logic [7:0] m2_tdata;
    logic       m2_tvalid;
    logic       m2_tlast;
    logic       m2_tready;
    logic       busy;

    int checks = 0;
    int errors = 0;

    axis_demux_1_2 #(.DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .s_tdata   (s_tdata),
        .s_tvalid  (s_tvalid),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m1_tdata  (m1_tdata),
        .m1_tvalid (m1_tvalid),
        .m1_tlast  (m1_tlast),
        .m1_tready (m1_tready),
        .m2_tdata  (m2_tdata),
        .m2_tvalid (m2_tvalid),
        .m2_tlast  (m2_tlast),
        .m2_tready (m2_tready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_q(input string nm, input logic [8:0] got[$], input logic [8:0] exp[$]);
        chk({nm, "_count"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            chk($sformatf("%s_beat%0d", nm, i), int'(got[i]), int'(exp[i]));
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: beats routed to a port but not yet taken by its
    // sink, the last beat loaded per port, and the open packet's port.
    // ------------------------------------------------------------------
    logic [8:0] q1[$];
    logic [8:0] q2[$];
    logic [8:0] h1;
    logic [8:0] h2;
    int         open_port;   // -1 none, 0 = m1, 1 = m2
    int         route_m;
    logic       exp_rdy;

    logic [8:0] log1[$];
    logic [8:0] log2[$];
    int         busy_cnt;
    int         stall_cnt;

    initial begin
        h1 = '0; h2 = '0; open_port = -1;
        busy_cnt = 0; stall_cnt = 0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            q1.delete(); q2.delete();
            h1 = '0; h2 = '0;
            open_port = -1;
        end
        route_m = (open_port >= 0) ? open_port : int'(sel);
        if (route_m == 0) exp_rdy = rst && (q1.size() == 0 || m1_tready);
        else              exp_rdy = rst && (q2.size() == 0 || m2_tready);

        chk("m1_tvalid", int'(m1_tvalid), int'(q1.size() != 0));
        chk("m1_tdata",  int'(m1_tdata),  int'(h1[7:0]));
        chk("m1_tlast",  int'(m1_tlast),  int'(h1[8]));
        chk("m2_tvalid", int'(m2_tvalid), int'(q2.size() != 0));
        chk("m2_tdata",  int'(m2_tdata),  int'(h2[7:0]));
        chk("m2_tlast",  int'(m2_tlast),  int'(h2[8]));
        chk("s_tready",  int'(s_tready),  int'(exp_rdy));
        chk("busy",      int'(busy),      int'(open_port >= 0));

        if (rst && m1_tvalid && m1_tready) log1.push_back({m1_tlast, m1_tdata});
        if (rst && m2_tvalid && m2_tready) log2.push_back({m2_tlast, m2_tdata});
        if (busy) busy_cnt++;
        if (rst && s_tvalid && !s_tready) stall_cnt++;

        // Advance the model to the state after the coming rising edge.
        if (rst) begin
            if (q1.size() != 0 && m1_tready) void'(q1.pop_front());
            if (q2.size() != 0 && m2_tready) void'(q2.pop_front());
            if (s_tvalid && exp_rdy) begin
                if (route_m == 0) begin q1.push_back({s_tlast, s_tdata}); h1 = {s_tlast, s_tdata}; end
                else              begin q2.push_back({s_tlast, s_tdata}); h2 = {s_tlast, s_tdata}; end
                if (open_port < 0) begin
                    if (!s_tlast) open_port = route_m;
                end else if (s_tlast) begin
                    open_port = -1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic send(input logic [7:0] d, input logic l, input logic s);
        bit done = 0;
        s_tdata  = d;
        s_tlast  = l;
        sel      = s;
        s_tvalid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (s_tready) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: beat %0h not accepted within 200 cycles", d);
        end
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log1.delete();
        log2.delete();
        busy_cnt  = 0;
        stall_cnt = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int sent_beats;
    int got_beats;
    bit rand_done;

    initial begin
        rst = 1'b0; sel = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        m1_tready = 1'b1; m2_tready = 1'b1;
        idle(3);
        chk("rst_m1_tdata",  int'(m1_tdata), 0);
        chk("rst_m2_tvalid", int'(m2_tvalid), 0);
        chk("rst_s_tready",  int'(s_tready), 0);
        chk("rst_busy",      int'(busy), 0);
        rst = 1'b1;
        idle(2);

        // Basic 3-beat packet to m1.
        clear_logs();
        send(8'h11, 0, 0); send(8'h22, 0, 0); send(8'h33, 1, 0);
        idle(3);
        chk_q("t1_m1", log1, '{9'h011, 9'h022, 9'h133});
        chk("t1_m2_count", log2.size(), 0);
        chk("t1_busy_cycles", busy_cnt, 2);

        // sel flips mid-packet; next packet follows the new sel.
        clear_logs();
        send(8'hA0, 0, 0); send(8'hA1, 0, 1); send(8'hA2, 0, 1); send(8'hA3, 1, 1);
        send(8'hB0, 0, 1); send(8'hB1, 1, 1);
        idle(3);
        chk_q("t2_m1", log1, '{9'h0A0, 9'h0A1, 9'h0A2, 9'h1A3});
        chk_q("t2_m2", log2, '{9'h0B0, 9'h1B1});

        // m2 backpressure for 3 cycles.
        clear_logs();
        m2_tready = 1'b0;
        fork
            begin send(8'h40, 0, 1); send(8'h41, 0, 1); send(8'h42, 1, 1); end
            begin repeat (4) @(posedge clk); #1; m2_tready = 1'b1; end
        join
        idle(3);
        chk_q("t3_m2", log2, '{9'h040, 9'h041, 9'h142});
        chk("t3_stall_cycles", stall_cnt, 3);

        // m2 holds a beat while m1 streams at full rate.
        m2_tready = 1'b0;
        send(8'h4F, 1, 1);
        clear_logs();
        send(8'hC0, 0, 0); send(8'hC1, 1, 0);
        chk("t4_stall_cycles", stall_cnt, 0);
        idle(2);
        chk_q("t4_m1", log1, '{9'h0C0, 9'h1C1});
        m2_tready = 1'b1;
        idle(2);
        chk_q("t4_m2", log2, '{9'h14F});

        // Single-beat packets never set busy.
        clear_logs();
        send(8'h5A, 1, 0); send(8'h5B, 1, 1); send(8'h5C, 1, 0);
        idle(3);
        chk_q("t5_m1", log1, '{9'h15A, 9'h15C});
        chk_q("t5_m2", log2, '{9'h15B});
        chk("t5_busy_cycles", busy_cnt, 0);

        // Reset mid-packet with a held beat on m1.
        m1_tready = 1'b0;
        send(8'h70, 0, 0);
        chk("t6_pre_m1_tvalid", int'(m1_tvalid), 1);
        chk("t6_pre_busy", int'(busy), 1);
        #1 rst = 1'b0;
        #1;
        chk("t6_async_m1_tvalid", int'(m1_tvalid), 0);
        chk("t6_async_m1_tdata",  int'(m1_tdata), 0);
        chk("t6_async_busy",      int'(busy), 0);
        chk("t6_async_s_tready",  int'(s_tready), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        m1_tready = 1'b1;
        clear_logs();
        send(8'h77, 1, 1);
        idle(3);
        chk_q("t6_m2", log2, '{9'h177});
        chk("t6_m1_count", log1.size(), 0);

        // Randomized traffic with random sink backpressure.
        clear_logs();
        sent_beats = 0;
        rand_done  = 0;
        fork
            begin
                for (int p = 0; p < 150; p++) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) begin
                        send(8'($urandom), b == len - 1, 1'($urandom));
                        sent_beats++;
                        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    end
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    m1_tready = ($urandom_range(0, 3) != 0);
                    m2_tready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m1_tready = 1'b1;
        m2_tready = 1'b1;
        idle(5);
        got_beats = log1.size() + log2.size();
        chk("rand_beat_total", got_beats, sent_beats);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
